// File: rtl/uart_tx_sched.sv
// uart_tx_sched
//   Lets two byte producers share one UART TX pin. A round-robin arbiter
//   picks one requester, the byte is latched, and the frame goes out directly
//   on the pin: start bit, 8 data bits LSB first, parity bit, stop bit.
//   Every line bit lasts exactly N clocks. N is CLKS_FAST or CLKS_SLOW,
//   chosen by SW2 when the frame starts.
//
// Parameters
//   CLKS_FAST   clocks per bit when SW2=1
//   CLKS_SLOW   clocks per bit when SW2=0
//   PARITY_ODD  0 = even parity, 1 = odd parity
//
// Ports
//   clk                     system clock, rising edge
//   rst                     synchronous reset, active low
//   SW2                     baud select, sampled only at frame start
//   req_a, data_a, ack_a    requester A: request, byte, one-cycle accept pulse
//   req_b, data_b, ack_b    requester B: same handshake as A
//   tx                      serial line, idle high, registered
//   busy                    high while a frame is in progress
//   gnt_b                   owner of the current or last frame (0=A, 1=B)
module uart_tx_sched #(
    parameter int unsigned CLKS_FAST  = 434,
    parameter int unsigned CLKS_SLOW  = 5208,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SW2,
    input  logic       req_a,
    input  logic [7:0] data_a,
    output logic       ack_a,
    input  logic       req_b,
    input  logic [7:0] data_b,
    output logic       ack_b,
    output logic       tx,
    output logic       busy,
    output logic       gnt_b
);

    localparam logic [12:0] PER_FAST = 13'(CLKS_FAST);
    localparam logic [12:0] PER_SLOW = 13'(CLKS_SLOW);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  data_q,   data_d;
    logic [2:0]  bit_q,    bit_d;
    logic [12:0] cnt_q,    cnt_d;
    logic [12:0] period_q, period_d;
    logic        tx_q,     tx_d;
    logic        ack_a_q,  ack_a_d;
    logic        ack_b_q,  ack_b_d;
    logic        gnt_q,    gnt_d;
    logic        last_q,   last_d;

    logic        pick_b;
    logic        bit_end;
    logic        parity_bit;

    // B wins if it is the only requester, or on a tie when A was granted last.
    assign pick_b     = req_b && (!req_a || !last_q);
    assign bit_end    = (cnt_q == period_q);
    assign parity_bit = PARITY_ODD ? ~^data_q : ^data_q;

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        bit_d    = bit_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        tx_d     = tx_q;
        ack_a_d  = 1'b0;
        ack_b_d  = 1'b0;
        gnt_d    = gnt_q;
        last_d   = last_q;

        if (state_q == IDLE) begin
            tx_d  = 1'b1;
            cnt_d = '0;
            if (req_a || req_b) begin
                data_d   = pick_b ? data_b : data_a;
                ack_a_d  = !pick_b;
                ack_b_d  = pick_b;
                gnt_d    = pick_b;
                last_d   = pick_b;
                period_d = SW2 ? PER_FAST : PER_SLOW;
                bit_d    = '0;
                tx_d     = 1'b0;
                cnt_d    = 13'd1;
                state_d  = START;
            end
        end else if (!bit_end) begin
            cnt_d = cnt_q + 13'd1;
        end else begin
            // Bit boundary: reload the timer and present the next line bit.
            cnt_d = 13'd1;
            case (state_q)
                START: begin
                    tx_d    = data_q[0];
                    bit_d   = '0;
                    state_d = DATA;
                end
                DATA: begin
                    if (bit_q == 3'd7) begin
                        tx_d    = parity_bit;
                        state_d = PARITY;
                    end else begin
                        tx_d  = data_q[bit_q + 3'd1];
                        bit_d = bit_q + 3'd1;
                    end
                end
                PARITY: begin
                    tx_d    = 1'b1;
                    state_d = STOP;
                end
                STOP: begin
                    tx_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
                default: begin
                    tx_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            data_q   <= '0;
            bit_q    <= '0;
            cnt_q    <= '0;
            period_q <= PER_FAST;
            tx_q     <= 1'b1;
            ack_a_q  <= 1'b0;
            ack_b_q  <= 1'b0;
            gnt_q    <= 1'b0;
            last_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            bit_q    <= bit_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            tx_q     <= tx_d;
            ack_a_q  <= ack_a_d;
            ack_b_q  <= ack_b_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
        end
    end

    assign tx    = tx_q;
    assign busy  = (state_q != IDLE);
    assign ack_a = ack_a_q;
    assign ack_b = ack_b_q;
    assign gnt_b = gnt_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched
//   Two instances: u0 with even parity, u1 with odd parity, both with short
//   bit periods. Stimulus pushes the expected frame (owner, byte, period) to a
//   per-instance queue. A monitor pops the entry on the ack pulse and checks
//   tx, busy, acks and gnt_b on every cycle of the frame and while idle.
`timescale 1ns/1ps
module tb_uart_tx_sched;

    localparam int unsigned NF = 16;
    localparam int unsigned NS = 40;

    typedef struct {
        bit          who_b;
        logic [7:0]  dat;
        int unsigned n;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_v   [2];
    logic       sw2_v   [2];
    logic       req_a_v [2];
    logic       req_b_v [2];
    logic [7:0] data_a_v[2];
    logic [7:0] data_b_v[2];
    logic       tx_w    [2];
    logic       busy_w  [2];
    logic       ack_a_w [2];
    logic       ack_b_w [2];
    logic       gnt_w   [2];

    bit          rst_q [2];
    bit          active[2];
    exp_t        q0[$];
    exp_t        q1[$];
    int unsigned ack_stamp[$];
    int unsigned cyc_now = 0;
    int          n_tests = 0;
    int          n_fail  = 0;

    always @(posedge clk) cyc_now <= cyc_now + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_now);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : mon
        uart_tx_sched #(
            .CLKS_FAST (NF),
            .CLKS_SLOW (NS),
            .PARITY_ODD(g == 1)
        ) dut (
            .clk   (clk),
            .rst   (rst_v[g]),
            .SW2   (sw2_v[g]),
            .req_a (req_a_v[g]),
            .data_a(data_a_v[g]),
            .ack_a (ack_a_w[g]),
            .req_b (req_b_v[g]),
            .data_b(data_b_v[g]),
            .ack_b (ack_b_w[g]),
            .tx    (tx_w[g]),
            .busy  (busy_w[g]),
            .gnt_b (gnt_w[g])
        );

        always @(posedge clk) rst_q[g] <= rst_v[g];

        exp_t        cur;
        int unsigned cyc = 0;
        logic        exp_gnt = 1'b0;
        logic [10:0] bits;
        bit          par;

        always @(negedge clk) begin
            if (!rst_q[g]) begin
                active[g] = 1'b0;
                exp_gnt   = 1'b0;
                check_eq("rst_tx",    tx_w[g],    1);
                check_eq("rst_busy",  busy_w[g],  0);
                check_eq("rst_ack_a", ack_a_w[g], 0);
                check_eq("rst_ack_b", ack_b_w[g], 0);
                check_eq("rst_gnt_b", gnt_w[g],   0);
            end else begin
                if (!active[g] && (ack_a_w[g] || ack_b_w[g])) begin
                    if ((g == 0 && q0.size() == 0) || (g == 1 && q1.size() == 0)) begin
                        check_eq("unexpected_ack", {ack_a_w[g], ack_b_w[g]}, 2'b00);
                    end else begin
                        if (g == 0) cur = q0.pop_front();
                        else        cur = q1.pop_front();
                        par  = (($countones(cur.dat) % 2) == 1) ^ (g == 1);
                        bits = {1'b1, par, cur.dat, 1'b0};
                        check_eq("ack_owner", {ack_a_w[g], ack_b_w[g]}, cur.who_b ? 2'b01 : 2'b10);
                        exp_gnt   = cur.who_b;
                        active[g] = 1'b1;
                        cyc       = 0;
                        if (g == 0) ack_stamp.push_back(cyc_now);
                    end
                end
                if (active[g]) begin
                    if (cyc == 11 * cur.n) begin
                        check_eq("end_tx",   tx_w[g],   1);
                        check_eq("end_busy", busy_w[g], 0);
                        check_eq("end_ack",  {ack_a_w[g], ack_b_w[g]}, 2'b00);
                        active[g] = 1'b0;
                    end else begin
                        check_eq("frame_tx",   tx_w[g],   bits[cyc / cur.n]);
                        check_eq("frame_busy", busy_w[g], 1);
                        if (cyc != 0) check_eq("frame_ack", {ack_a_w[g], ack_b_w[g]}, 2'b00);
                        cyc++;
                    end
                end else begin
                    check_eq("idle_tx",   tx_w[g],   1);
                    check_eq("idle_busy", busy_w[g], 0);
                end
                check_eq("gnt_b", gnt_w[g], exp_gnt);
            end
        end
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int g, input bit who_b, input logic [7:0] d, input int unsigned n);
        exp_t e;
        e.who_b = who_b;
        e.dat   = d;
        e.n     = n;
        if (g == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic wait_ack(input int g, input string tag);
        int unsigned k = 0;
        do begin
            tick(1);
            k++;
        end while (!(ack_a_w[g] || ack_b_w[g]) && k < 12 * NS);
        check_eq({tag, "_ack_seen"}, ack_a_w[g] | ack_b_w[g], 1);
    endtask

    task automatic wait_idle(input string tag);
        int unsigned k = 0;
        do begin
            tick(1);
            k++;
        end while ((q0.size() != 0 || q1.size() != 0 || active[0] || active[1]) && k < 30 * NS);
        check_eq({tag, "_drain"}, q0.size() + q1.size() + active[0] + active[1], 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_v[i]    = 1'b0;
            sw2_v[i]    = 1'b1;
            req_a_v[i]  = 1'b0;
            req_b_v[i]  = 1'b0;
            data_a_v[i] = '0;
            data_b_v[i] = '0;
        end
        tick(3);
        rst_v[0] = 1'b1;
        rst_v[1] = 1'b1;
        tick(2);

        // Single A frame, 0x55, fast rate.
        data_a_v[0] = 8'h55;
        req_a_v[0]  = 1'b1;
        push(0, 1'b0, 8'h55, NF);
        wait_ack(0, "t1");
        req_a_v[0] = 1'b0;
        wait_idle("t1");

        // Both requesting out of reset: A, B, A, B back to back.
        rst_v[0]    = 1'b0;
        req_a_v[0]  = 1'b1;
        req_b_v[0]  = 1'b1;
        data_a_v[0] = 8'hC3;
        data_b_v[0] = 8'h2E;
        push(0, 1'b0, 8'hC3, NF);
        push(0, 1'b1, 8'h2E, NF);
        push(0, 1'b0, 8'h91, NF);
        push(0, 1'b1, 8'h7A, NF);
        ack_stamp.delete();
        tick(2);
        rst_v[0] = 1'b1;
        wait_ack(0, "t2a1");
        data_a_v[0] = 8'h91;
        wait_ack(0, "t2b1");
        data_b_v[0] = 8'h7A;
        wait_ack(0, "t2a2");
        req_a_v[0] = 1'b0;
        wait_ack(0, "t2b2");
        req_b_v[0] = 1'b0;
        wait_idle("t2");
        check_eq("t2_ack_count", ack_stamp.size(), 4);
        for (int i = 1; i < ack_stamp.size(); i++)
            check_eq("t2_ack_spacing", ack_stamp[i] - ack_stamp[i-1], 11 * NF + 1);

        // Slow rate from B, SW2 toggled mid-frame, then a fast A frame.
        sw2_v[0]    = 1'b0;
        data_b_v[0] = 8'h80;
        req_b_v[0]  = 1'b1;
        push(0, 1'b1, 8'h80, NS);
        wait_ack(0, "t3b");
        req_b_v[0]  = 1'b0;
        data_b_v[0] = 8'hFF;
        tick(3 * NS);
        sw2_v[0] = 1'b1;
        tick(2 * NS);
        sw2_v[0] = 1'b0;
        tick(NS);
        sw2_v[0] = 1'b1;
        wait_idle("t3b");
        data_a_v[0] = 8'h3C;
        req_a_v[0]  = 1'b1;
        push(0, 1'b0, 8'h3C, NF);
        wait_ack(0, "t3a");
        req_a_v[0] = 1'b0;
        wait_idle("t3a");

        // Odd parity instance: 0x00 then 0xFF, both parity bits 1.
        data_a_v[1] = 8'h00;
        req_a_v[1]  = 1'b1;
        push(1, 1'b0, 8'h00, NF);
        push(1, 1'b0, 8'hFF, NF);
        wait_ack(1, "t4a");
        data_a_v[1] = 8'hFF;
        wait_ack(1, "t4b");
        req_a_v[1] = 1'b0;
        wait_idle("t4");

        // Reset in the middle of the data bits, req_a held throughout.
        data_a_v[0] = 8'hA5;
        req_a_v[0]  = 1'b1;
        push(0, 1'b0, 8'hA5, NF);
        wait_ack(0, "t5a");
        tick(3 * NF);
        rst_v[0] = 1'b0;
        push(0, 1'b0, 8'hA5, NF);
        tick(1);
        check_eq("t5_rst_tx",   tx_w[0],   1);
        check_eq("t5_rst_busy", busy_w[0], 0);
        rst_v[0] = 1'b1;
        wait_ack(0, "t5b");
        req_a_v[0] = 1'b0;
        wait_idle("t5");

        // B requests for a single cycle during an A frame and is never served.
        data_a_v[0] = 8'h0F;
        req_a_v[0]  = 1'b1;
        push(0, 1'b0, 8'h0F, NF);
        wait_ack(0, "t6");
        req_a_v[0] = 1'b0;
        tick(2 * NF);
        data_b_v[0] = 8'h99;
        req_b_v[0]  = 1'b1;
        tick(1);
        req_b_v[0] = 1'b0;
        wait_idle("t6");
        tick(4 * NF);
        check_eq("t6_gnt_b", gnt_w[0], 0);
        check_eq("t6_tx",    tx_w[0],  1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

UART transmit scheduler that lets two byte sources share one serial TX line. It arbitrates round-robin between requesters A and B, latches the winning byte, and produces the line waveform directly: start bit, 8 data bits LSB-first, parity bit, stop bit (11 bits per frame). It owns the baud bit-timer, runs at 434 or 5208 clocks per bit selected by SW2, and sits between the byte producers and the TX pin.

## Interface
- CLKS_FAST, 434: clocks per bit when SW2=1 (115200 baud @ 50 MHz).
- CLKS_SLOW, 5208: clocks per bit when SW2=0 (9600 baud @ 50 MHz).
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd parity.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- SW2  in  1  baud select, sampled only at frame start.
- req_a  in  1  requester A has a byte; held high until ack_a.
- data_a  in  8  requester A byte; stable while req_a high.
- ack_a  out  1  one-cycle pulse: data_a latched, frame started.
- req_b / data_b / ack_b: same as the A port, for requester B.
- tx  out  1  serial line, idle high, registered.
- busy  out  1  high while a frame is in progress.
- gnt_b  out  1  owner of the current or last frame: 0=A, 1=B.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. busy = (state != IDLE).
- IDLE, edge with any req high: select the winner and latch its byte into the shift register. Pulse that port's ack for 1 cycle. Set gnt_b. Latch SW2 into the bit-period register. Set tx<=0, bit counter<=1, state<=START.
- Arbitration: if only one req is high, that port wins. If both are high, the port not granted last time wins. last_grant resets to B, so A wins the first tie.
- Bit timer: 13-bit counter runs 1..N, where N = CLKS_FAST or CLKS_SLOW per latched SW2. At count==N it reloads to 1 and the bit advances. Each line bit is therefore exactly N cycles.
- START -> DATA: tx = data[0], bit index = 0.
- DATA: on each boundary, shift to the next bit. After data[7]'s boundary, go to PARITY.
- PARITY: tx = ^data (even) or ~^data (odd).
- PARITY -> STOP: tx = 1.
- STOP boundary -> IDLE. tx stays 1 and the timer counter clears to 0.
- Drop rule: a req deasserted before its ack is never served. No partial state is kept.
- Changes to SW2 or data inputs during a frame have no effect.
- Reset mid-frame: the next rising edge with rst=0 forces state=IDLE, tx=1, acks=0, counter=0, last_grant=B, gnt_b=0. No ack is issued and the frame is aborted.

## Timing
- Reset values: tx=1, busy=0, ack_a=0, ack_b=0, gnt_b=0.
- Ack edge = cycle T. ack_x is high during cycle T+1 only, and tx=0 from T+1.
- Start bit occupies cycles T+1..T+N. Data bit k occupies T+1+(k+1)N .. T+(k+2)N. Parity and stop follow. busy is high for exactly 11N cycles.
- After the stop bit, at least 1 cycle in IDLE. Back-to-back ack period = 11N+1 cycles.
- Arbitration decision uses req values sampled at the IDLE edge only. No combinational path from req to ack.

## Test plan
- Single A, 0x55, SW2=1: one ack_a pulse. tx = 0,1,0,1,0,1,0,1,0,0(parity),1, each held 434 cycles. busy high 4774 cycles, gnt_b=0.
- A and B both high from reset, SW2=1: order A,B,A,B. gnt_b toggles each frame. Ack-to-ack spacing is 4775 cycles.
- SW2=0, B sends 0x80: bit period is 5208 cycles and parity=1. Toggling SW2 mid-frame leaves the period unchanged. The next frame uses the new SW2.
- PARITY_ODD=1, byte 0x00: parity bit 1. Byte 0xFF: parity bit 1.
- rst low mid-DATA: tx=1 and busy=0 on the next edge, with no extra ack. After release, held req_a gets a fresh full frame.
- req_b pulsed for 1 cycle during a busy A frame, then dropped: no ack_b, and the line stays idle after the A frame.
